// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a valid/ready request channel
// and a valid/ready response channel, with a programmable number of wait
// states before every access.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_we           1 = write, 0 = read
//   req_addr         byte address (must be word aligned and in range)
//   req_wdata        write data
//   rsp_valid/ready  response handshake
//   rsp_rdata        read data (0 for writes and errors)
//   rsp_err          misaligned or out-of-range request
//   dbg_addr/data    combinational side read of the array by word index
//   rsp_count        completed responses, wraps at 16 bits
//
// Timing: acceptance edge E0, the access happens on edge E(WAIT_CYCLES+1)
// and rsp_valid is raised on that same edge. WAIT_CYCLES must be 0..15.
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    input  logic [DEPTH_LOG2-1:0] dbg_addr,
    output logic [31:0]           dbg_data,
    output logic [15:0]           rsp_count
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wait_cnt;
    req_t                  req_q;
    logic [31:0]           mem [DEPTH];
    logic                  accept;
    logic                  handshake;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] word_idx;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign handshake = (state == S_RESP) && rsp_ready;
    assign word_idx  = req_q.addr[DEPTH_LOG2+1:2];
    // Anything above the array's byte range, or a non-word offset, is an error.
    assign req_err   = (req_q.addr[1:0] != 2'b00) ||
                       ((req_q.addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign dbg_data  = mem[dbg_addr];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            // <= 1 rather than == 1 so a corrupted zero count cannot stall.
            S_WAIT:   if (wait_cnt <= 4'd1) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= 4'd0;
            req_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            rsp_count <= 16'd0;
        end else begin
            if (accept) begin
                req_q.we    <= req_we;
                req_q.addr  <= req_addr;
                req_q.wdata <= req_wdata;
                wait_cnt    <= WAIT_INIT;
            end

            if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;

            if (state == S_ACCESS) begin
                rsp_valid <= 1'b1;
                rsp_err   <= req_err;
                rsp_rdata <= (!req_err && !req_q.we) ? mem[word_idx] : 32'd0;
            end

            if (handshake) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
                rsp_count <= rsp_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset, contents survive rst. Reset forces IDLE, so an
    // aborted transaction never reaches ACCESS and never writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && req_q.we && !req_err)
            mem[word_idx] <= req_q.wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];
    logic [7:0]  dbg_addr   [2];
    logic [31:0] dbg_data   [2];
    logic [15:0] rsp_count  [2];

    // Reference model: word array, response counter, last acceptance time.
    logic [31:0] mdl   [2][256];
    logic [15:0] cnt_m [2];
    time         acc_t [2];
    int          n_assert = 0;
    int          n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u_a: WAIT_CYCLES=2, u_b: WAIT_CYCLES=0
    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]),
        .rsp_count(rsp_count[0])
    );

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]),
        .rsp_count(rsp_count[1])
    );

    function automatic int wc(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic rst_check(input int s);
        chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[s], 32'd0);
        chk("rst_rsp_err",   32'(rsp_err[s]), 32'd0);
        chk("rst_rsp_count", 32'(rsp_count[s]), 32'd0);
    endtask

    // Full transaction: drive, check latency, response, hold stability,
    // handshake and counter. Inputs are scrambled right after acceptance,
    // and junk requests may be offered while the block is busy.
    task automatic txn(input int s, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input bit chk_space);
        bit          err;
        int          idx;
        logic [31:0] exp_rd;
        err = (addr % 4 != 0) || (addr >= 32'd1024);
        idx = int'((addr / 4) % 256);
        @(negedge clk);
        rsp_ready[s] = (hold == 0);
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        dbg_addr[s]  = 8'(idx);
        chk("req_ready_idle", 32'(req_ready[s]), 32'd1);
        @(posedge clk);
        if (chk_space) chk("accept_spacing", 32'(($time - acc_t[s]) / 10), 32'(wc(s) + 3));
        acc_t[s] = $time;
        #1;
        req_valid[s] = 1'($urandom);
        req_we[s]    = 1'($urandom);
        req_addr[s]  = {22'd0, 8'($urandom), 2'd0};
        req_wdata[s] = $urandom;
        exp_rd = (err || we) ? 32'd0 : mdl[s][idx];
        if (!err && we) mdl[s][idx] = wdata;
        for (int k = 1; k <= wc(s) + 1; k++) begin
            chk("rsp_valid_early", 32'(rsp_valid[s]), 32'd0);
            chk("req_ready_busy", 32'(req_ready[s]), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("rsp_valid_rise", 32'(rsp_valid[s]), 32'd1);
        chk("rsp_err", 32'(rsp_err[s]), 32'(err));
        chk("rsp_rdata", rsp_rdata[s], exp_rd);
        chk("dbg_after_access", dbg_data[s], mdl[s][idx]);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid[s]), 32'd1);
            chk("hold_err", 32'(rsp_err[s]), 32'(err));
            chk("hold_rdata", rsp_rdata[s], exp_rd);
            chk("hold_req_ready", 32'(req_ready[s]), 32'd0);
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        cnt_m[s] = cnt_m[s] + 16'd1;
        chk("rsp_valid_drop", 32'(rsp_valid[s]), 32'd0);
        chk("rsp_count", 32'(rsp_count[s]), 32'(cnt_m[s]));
        chk("req_ready_back", 32'(req_ready[s]), 32'd1);
    endtask

    task automatic rand_txn(input int s);
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = {22'd0, 8'($urandom), 2'd0};
        if (r == 7) a = a | 32'($urandom_range(1, 3));
        if (r >= 8) a = $urandom | 32'h0000_0400;
        txn(s, 1'($urandom), a, $urandom, $urandom_range(0, 3), 1'b0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b0; req_valid[s] = 1'b0; req_we[s] = 1'b0;
            req_addr[s] = 32'd0; req_wdata[s] = 32'd0; rsp_ready[s] = 1'b0;
            dbg_addr[s] = 8'd0; cnt_m[s] = 16'd0; acc_t[s] = 0;
        end
        #12;
        rst_check(0);
        rst_check(1);
        @(posedge clk); #2;
        rst[0] = 1'b1; rst[1] = 1'b1;

        // Fill both arrays so every later read has a defined expectation.
        for (int i = 0; i < 256; i++) txn(0, 1'b1, 32'(i * 4), $urandom, 0, 1'b0);
        for (int i = 0; i < 256; i++) txn(1, 1'b1, 32'(i * 4), $urandom, 0, 1'b0);

        // Reset clears the counter but keeps the array.
        @(negedge clk); #2;
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        rst_check(0);
        rst_check(1);
        cnt_m[0] = 16'd0; cnt_m[1] = 16'd0;
        @(posedge clk); #2;
        rst[0] = 1'b1; rst[1] = 1'b1;
        dbg_addr[0] = 8'd77;
        #1;
        chk("array_kept_over_reset", dbg_data[0], mdl[0][77]);

        // Write, readback with a long stall, then two error requests.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        chk("count_first", 32'(rsp_count[0]), 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b0);
        chk("raw_model", mdl[0][4], 32'hDEADBEEF);
        txn(0, 1'b1, 32'h12, 32'h1234_5678, 0, 1'b0);
        txn(0, 1'b0, 32'h400, 32'h0, 1, 1'b0);
        dbg_addr[0] = 8'd4;
        #1;
        chk("err_write_no_effect", dbg_data[0], 32'hDEADBEEF);

        // Zero wait states, back-to-back with rsp_ready held high.
        txn(1, 1'b1, 32'h40, 32'hA5A5_0001, 0, 1'b0);
        txn(1, 1'b1, 32'h44, 32'hA5A5_0002, 0, 1'b1);
        txn(1, 1'b0, 32'h40, 32'h0, 0, 1'b1);
        txn(1, 1'b0, 32'h44, 32'h0, 0, 1'b1);

        // Reset while a write to 0x20 sits in WAIT: aborted, array untouched.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h5555_AAAA;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst[0] = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_count", 32'(rsp_count[0]), 32'd0);
        cnt_m[0] = 16'd0;
        repeat (2) @(posedge clk);
        #2;
        rst[0] = 1'b1;
        dbg_addr[0] = 8'd8;
        #1;
        chk("abort_no_write", dbg_data[0], mdl[0][8]);
        txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 60; i++) rand_txn(0);
        for (int i = 0; i < 60; i++) rand_txn(1);

        // Counter wrap.
        @(negedge clk);
        force u_b.rsp_count = 16'hFFFF;
        #1;
        release u_b.rsp_count;
        cnt_m[1] = 16'hFFFF;
        #1;
        chk("count_preload", 32'(rsp_count[1]), 32'h0000_FFFF);
        txn(1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        chk("count_wrap", 32'(rsp_count[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, number of word-address bits (storage = 2^DEPTH_LOG2 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each access; legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately regardless of clk.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator takes the response this cycle.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.
REQ-014 dbg_addr  input  DEPTH_LOG2  word index for the debug read port.
REQ-015 dbg_data  output  32  combinational read of the word at dbg_addr.
REQ-016 rsp_count  output  16  number of completed responses.

Function
REQ-017 The block SHALL implement a four-state FSM: IDLE, WAIT, ACCESS, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-019 On acceptance the block SHALL register req_we, req_addr and req_wdata; later input changes SHALL NOT affect the transaction.
REQ-020 On acceptance the FSM SHALL go to WAIT with the counter set to WAIT_CYCLES, or directly to ACCESS if WAIT_CYCLES=0.
REQ-021 In WAIT the counter SHALL decrement on each edge, and the FSM SHALL go to ACCESS on the edge where the counter equals 1.
REQ-022 Call the acceptance edge E0. The ACCESS edge SHALL be E(WAIT_CYCLES+1), and rsp_valid SHALL be 1 from that edge onward.
REQ-023 A request SHALL be an error if captured addr[1:0] != 0 or addr[31:DEPTH_LOG2+2] != 0; the word index is addr[DEPTH_LOG2+1:2].
REQ-024 On the ACCESS edge, a non-error write SHALL store the data to the array; a non-error read SHALL register array data into rsp_rdata.
REQ-025 An error request SHALL leave the array unchanged, return rsp_rdata=0 and rsp_err=1, and take the same latency as a good request.
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1. On that edge the FSM SHALL return to IDLE, rsp_valid SHALL go to 0, and rsp_count SHALL increment.
REQ-027 rsp_count SHALL wrap from 0xFFFF to 0x0000.
REQ-028 rsp_ready=1 outside RESP SHALL have no effect; req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-029 Minimum spacing between acceptances SHALL be WAIT_CYCLES+3 cycles when rsp_ready is held at 1.
REQ-030 For a read-after-write to the same word, the read SHALL return the newly written data.
REQ-031 dbg_data SHALL reflect a write from the first cycle after its ACCESS edge.

Reset
REQ-032 While rst=0: FSM=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_count=0.
REQ-033 Reset SHALL NOT clear the array; contents are retained across reset and are undefined at power-up.
REQ-034 Reset asserted before the ACCESS edge SHALL abort the transaction with no array write and no response.
REQ-035 After rst returns to 1, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-036 WAIT_CYCLES=2; write 0xDEADBEEF to 0x10 at E0 -> rsp_valid rises after E3 with rsp_err=0 and rsp_rdata=0; dbg_addr=4 gives 0xDEADBEEF; rsp_count=1 after handshake.
REQ-037 Read of 0x10 after REQ-036 -> rsp_rdata=0xDEADBEEF after E3; hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0 throughout.
REQ-038 Write to 0x12 and read of 0x400 (DEPTH_LOG2=8) -> both give rsp_err=1 and rsp_rdata=0; the array is unchanged (spot-check via dbg).
REQ-039 WAIT_CYCLES=0; back-to-back requests with rsp_ready=1 -> acceptances 3 cycles apart; second request's inputs changed mid-flight have no effect.
REQ-040 Pull rst low during WAIT of a write to 0x20 -> rsp_valid=0 immediately; dbg at word 8 shows the old value; a next request is accepted normally.
REQ-041 Preload rsp_count to 0xFFFF via 65535 transactions (or force) -> next handshake gives rsp_count=0x0000.
